// File: rtl/fetch_decode_queue_if.sv
// Handshake bundle for the fetch/decode queue.
// Carries three groups of signals:
//   - the byte memory read port (mem_req/mem_addr/mem_ack/mem_rdata),
//   - the redirect request (flush/flush_pc),
//   - the decoded instruction stream (dec_valid/dec_ready/dec_inst/dec_pc/dec_bytes/dec_imm).
// master : the fetch unit side (drives requests and decoded instructions)
// slave  : the environment side (memory, branch unit, decoder consumer)
interface fetch_decode_queue_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              dec_valid;
  logic              dec_ready;
  logic [15:0]       dec_inst;
  logic [ADDR_W-1:0] dec_pc;
  logic [1:0]        dec_bytes;
  logic [DATA_W-1:0] dec_imm;

  modport master (
    output mem_req, mem_addr, dec_valid, dec_inst, dec_pc, dec_bytes, dec_imm,
    input  mem_ack, mem_rdata, flush, flush_pc, dec_ready
  );

  modport slave (
    input  mem_req, mem_addr, dec_valid, dec_inst, dec_pc, dec_bytes, dec_imm,
    output mem_ack, mem_rdata, flush, flush_pc, dec_ready
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Byte-wide instruction fetch front end.
// Prefetches program bytes into a small FIFO, assembles 1- or 2-byte
// instructions (2 bytes when the first byte has bit7 set, first byte in
// inst[15:8]) and presents them with their PC, length and a pre-extracted
// immediate over a valid/ready handshake. A flush discards everything
// fetched so far and restarts fetching at flush_pc.
// Ports:
//   clk    - clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - fetch_decode_queue_if.master: memory read port, redirect,
//            decoded instruction output
module fetch_decode_queue #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  fetch_decode_queue_if.master bus
);

  localparam int               PTR_W   = $clog2(QDEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fetchState_t;

  fetchState_t       r_state;
  fetchState_t       w_stateNext;

  logic [7:0]        r_fifoData [QDEPTH];
  logic [ADDR_W-1:0] r_fifoAddr [QDEPTH];
  logic [PTR_W-1:0]  r_rdPtr;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] r_fetchPc;
  logic [ADDR_W-1:0] r_memAddr;
  logic              r_dropAck;

  logic              r_decValid;
  logic [15:0]       r_decInst;
  logic [ADDR_W-1:0] r_decPc;
  logic [1:0]        r_decBytes;
  logic [DATA_W-1:0] r_decImm;

  logic              w_memReq;
  logic              w_startReq;
  logic              w_pushByte;
  logic [7:0]        w_head;
  logic [7:0]        w_next;
  logic              w_canLoad;
  logic              w_load1;
  logic              w_load2;
  logic              w_load;
  logic [15:0]       w_inst;
  logic [CNT_W-1:0]  w_popCnt;

  // Immediate pre-extraction for the downstream decoder.
  function automatic logic [DATA_W-1:0] immOf(input logic [15:0] i);
    logic [DATA_W-1:0] imm;
    imm = '0;
    if (i[15:11] == 5'b11000 || i[15:11] == 5'b11010) begin
      imm = {{(DATA_W-11){i[10]}}, i[10:0]};
    end else if (i[15:14] == 2'b10) begin
      if (i[10:8] == 3'b000 || i[10] == 1'b1) begin
        imm = DATA_W'(i[7:0]);
      end else if (i[10:8] == 3'b001) begin
        imm = DATA_W'({i[7:0], 8'h00});
      end
    end
    return imm;
  endfunction

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Fetch FSM: a request is only started when the FIFO has room, and with
  // at most one request outstanding the FIFO can never overflow. A flush in
  // IDLE just delays the start by a cycle; a flush in REQ keeps the request
  // alive until its ack (the byte is discarded via r_dropAck or flush).
  always_comb begin
    w_stateNext = r_state;
    w_memReq    = 1'b0;
    w_startReq  = 1'b0;
    w_pushByte  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.flush && r_count < DEPTH_C) begin
          w_stateNext = S_REQ;
          w_startReq  = 1'b1;
        end
      end
      S_REQ: begin
        w_memReq = 1'b1;
        if (bus.mem_ack) begin
          w_stateNext = S_IDLE;
          w_pushByte  = !r_dropAck && !bus.flush;
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // Instruction assembly from the FIFO head. A 2-byte instruction is only
  // taken once both bytes are queued, so there is never a partial output.
  always_comb begin
    w_head    = r_fifoData[r_rdPtr];
    w_next    = r_fifoData[r_rdPtr + PTR_W'(1)];
    w_canLoad = !r_decValid || bus.dec_ready;
    w_load1   = w_canLoad && (r_count != '0) && !w_head[7];
    w_load2   = w_canLoad && (r_count >= CNT_W'(2)) && w_head[7];
    w_load    = (w_load1 || w_load2) && !bus.flush;
    w_inst    = w_head[7] ? {w_head, w_next} : {w_head, 8'h00};
    w_popCnt  = '0;
    if (w_load2) begin
      w_popCnt = CNT_W'(2);
    end else if (w_load1) begin
      w_popCnt = CNT_W'(1);
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_pushByte) begin
      r_fifoData[r_wrPtr] <= bus.mem_rdata;
      r_fifoAddr[r_wrPtr] <= r_memAddr;
    end
  end

  // Control, fetch address and output register. Flush wins over every
  // other update in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_fetchPc  <= RESET_PC;
      r_memAddr  <= RESET_PC;
      r_dropAck  <= 1'b0;
      r_decValid <= 1'b0;
      r_decInst  <= '0;
      r_decPc    <= '0;
      r_decBytes <= '0;
      r_decImm   <= '0;
    end else begin
      if (w_startReq) begin
        r_memAddr <= r_fetchPc;
      end
      if (bus.flush) begin
        r_fetchPc  <= bus.flush_pc;
        r_rdPtr    <= '0;
        r_wrPtr    <= '0;
        r_count    <= '0;
        r_decValid <= 1'b0;
        r_dropAck  <= (r_state == S_REQ) && !bus.mem_ack;
      end else begin
        if (r_state == S_REQ && bus.mem_ack) begin
          r_dropAck <= 1'b0;
        end
        if (w_pushByte) begin
          r_wrPtr   <= r_wrPtr + PTR_W'(1);
          r_fetchPc <= r_memAddr + ADDR_W'(1);
        end
        r_rdPtr <= r_rdPtr + w_popCnt[PTR_W-1:0];
        r_count <= r_count + CNT_W'(w_pushByte) - w_popCnt;
        if (w_load) begin
          r_decValid <= 1'b1;
          r_decInst  <= w_inst;
          r_decPc    <= r_fifoAddr[r_rdPtr];
          r_decBytes <= w_head[7] ? 2'd2 : 2'd1;
          r_decImm   <= immOf(w_inst);
        end else if (bus.dec_ready) begin
          r_decValid <= 1'b0;
        end
      end
    end
  end

  assign bus.mem_req   = w_memReq;
  assign bus.mem_addr  = r_memAddr;
  assign bus.dec_valid = r_decValid;
  assign bus.dec_inst  = r_decInst;
  assign bus.dec_pc    = r_decPc;
  assign bus.dec_bytes = r_decBytes;
  assign bus.dec_imm   = r_decImm;

endmodule
